// File: rtl/aurora_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aurora_tx_arbiter
// Description : Frame-granular round-robin arbiter that shares the Aurora TX
//               AXI-Stream link between two sources.
//               s0 carries sequence-numbered data; s1 carries aux/control
//               frames. The grant is held for a whole frame, downstream
//               backpressure is honoured, and a stalled frame is closed with a
//               filler word. Completed frames are counted per source.
// Ports       : m_axis_aclk / m_axis_aresetn    clock, async active-low reset
//               s0_axis_* / s1_axis_*          source streams (tready out)
//               m_axis_*                        merged stream to Aurora TX
//               ctrl_src_en[1:0]                per-source grant enable
//               ctrl_rst_cntr                   level clear of counters/flags
//               slv_cntr_s0 / slv_cntr_s1       frames forwarded per source
//               sts_grant[1:0]                  one-hot owner of the link
//               sts_err_timeout[1:0]            sticky stall-abort flags
// Revision    : 1.0 - initial release
// ============================================================================
module aurora_tx_arbiter #(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    STALL_TIMEOUT = 1024,
   parameter logic [DATA_WIDTH-1:0] TERM_WORD     = DATA_WIDTH'(32'hDEAD_F00D)
) (
   input  logic                  m_axis_aclk,
   input  logic                  m_axis_aresetn,
   input  logic                  s0_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic                  s0_axis_tlast,
   output logic                  s0_axis_tready,
   input  logic                  s1_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic                  s1_axis_tlast,
   output logic                  s1_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   input  logic [1:0]            ctrl_src_en,
   input  logic                  ctrl_rst_cntr,
   output logic [31:0]           slv_cntr_s0,
   output logic [31:0]           slv_cntr_s1,
   output logic [1:0]            sts_grant,
   output logic [1:0]            sts_err_timeout
);

   localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GRANT0 = 3'd1,
      ST_GRANT1 = 3'd2,
      ST_TERM   = 3'd3,
      ST_DRAIN  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   // Source of the most recent grant; also names the owner while in
   // GRANT/TERM/DRAIN, since it is updated on grant entry.
   logic                 last_grant_q, last_grant_d;
   logic [STALL_W-1:0]   stall_q, stall_d;
   logic [31:0]          cntr_s0_q, cntr_s0_d;
   logic [31:0]          cntr_s1_q, cntr_s1_d;
   logic [1:0]           err_q, err_d;

   logic                 sel_valid;
   logic                 sel_last;
   logic [1:0]           cand;
   logic [1:0]           owner_onehot;

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         stall_q      <= '0;
         cntr_s0_q    <= '0;
         cntr_s1_q    <= '0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         stall_q      <= stall_d;
         cntr_s0_q    <= cntr_s0_d;
         cntr_s1_q    <= cntr_s1_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      stall_d        = '0;
      cntr_s0_d      = cntr_s0_q;
      cntr_s1_d      = cntr_s1_q;
      err_d          = err_q;
      m_axis_tvalid  = 1'b0;
      m_axis_tdata   = '0;
      m_axis_tlast   = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      sts_grant      = 2'b00;

      sel_valid    = last_grant_q ? s1_axis_tvalid : s0_axis_tvalid;
      sel_last     = last_grant_q ? s1_axis_tlast  : s0_axis_tlast;
      cand         = {s1_axis_tvalid & ctrl_src_en[1], s0_axis_tvalid & ctrl_src_en[0]};
      owner_onehot = last_grant_q ? 2'b10 : 2'b01;

      case (state_q)
         ST_IDLE: begin
            if (cand != 2'b00) begin
               // On a tie the source that did not win last time is served.
               if (cand == 2'b11) begin
                  last_grant_d = ~last_grant_q;
               end else begin
                  last_grant_d = cand[1];
               end
               state_d = (cand == 2'b11) ? (last_grant_q ? ST_GRANT0 : ST_GRANT1)
                                         : (cand[1] ? ST_GRANT1 : ST_GRANT0);
            end
         end

         ST_GRANT0, ST_GRANT1: begin
            m_axis_tvalid  = sel_valid;
            m_axis_tdata   = last_grant_q ? s1_axis_tdata : s0_axis_tdata;
            m_axis_tlast   = sel_last;
            s0_axis_tready = ~last_grant_q & m_axis_tready;
            s1_axis_tready =  last_grant_q & m_axis_tready;
            sts_grant      = owner_onehot;
            if (sel_valid) begin
               // Downstream backpressure never advances the stall count.
               if (m_axis_tready && sel_last) begin
                  state_d = ST_IDLE;
                  if (last_grant_q) begin
                     cntr_s1_d = (cntr_s1_q == 32'hFFFF_FFFF) ? cntr_s1_q : cntr_s1_q + 32'd1;
                  end else begin
                     cntr_s0_d = (cntr_s0_q == 32'hFFFF_FFFF) ? cntr_s0_q : cntr_s0_q + 32'd1;
                  end
               end
            end else if (stall_q == STALL_LAST) begin
               state_d             = ST_TERM;
               err_d[last_grant_q] = 1'b1;
            end else begin
               stall_d = stall_q + STALL_W'(1);
            end
         end

         ST_TERM: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = TERM_WORD;
            m_axis_tlast  = 1'b1;
            sts_grant     = owner_onehot;
            if (m_axis_tready) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Discard the rest of the aborted frame regardless of enables,
            // so a partially sent frame can never wedge the source.
            s0_axis_tready = ~last_grant_q;
            s1_axis_tready =  last_grant_q;
            sts_grant      = owner_onehot;
            if (sel_valid && sel_last) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Clear has priority over a coincident frame completion or abort.
      if (ctrl_rst_cntr) begin
         cntr_s0_d = '0;
         cntr_s1_d = '0;
         err_d     = '0;
      end
   end

   assign slv_cntr_s0     = cntr_s0_q;
   assign slv_cntr_s1     = cntr_s1_q;
   assign sts_err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aurora_tx_arbiter
// Description : Directed self-checking bench for aurora_tx_arbiter
//               (STALL_TIMEOUT overridden to 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aurora_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tready;
   logic [31:0] s0_tdata = '0;
   logic        s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tready;
   logic [31:0] s1_tdata = '0;
   logic        m_tvalid, m_tlast;
   logic [31:0] m_tdata;
   logic        m_tready = 1'b1;
   logic [1:0]  src_en = 2'b11;
   logic        rst_cntr = 1'b0;
   logic [31:0] cntr_s0, cntr_s1;
   logic [1:0]  grant, err;

   int n_checks = 0;
   int n_errors = 0;

   aurora_tx_arbiter #(
      .DATA_WIDTH   (32),
      .STALL_TIMEOUT(8),
      .TERM_WORD    (32'hDEAD_F00D)
   ) dut (
      .m_axis_aclk    (clk),
      .m_axis_aresetn (rst_n),
      .s0_axis_tvalid (s0_tvalid),
      .s0_axis_tdata  (s0_tdata),
      .s0_axis_tlast  (s0_tlast),
      .s0_axis_tready (s0_tready),
      .s1_axis_tvalid (s1_tvalid),
      .s1_axis_tdata  (s1_tdata),
      .s1_axis_tlast  (s1_tlast),
      .s1_axis_tready (s1_tready),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tdata   (m_tdata),
      .m_axis_tlast   (m_tlast),
      .m_axis_tready  (m_tready),
      .ctrl_src_en    (src_en),
      .ctrl_rst_cntr  (rst_cntr),
      .slv_cntr_s0    (cntr_s0),
      .slv_cntr_s1    (cntr_s1),
      .sts_grant      (grant),
      .sts_err_timeout(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx0, idx1, k, n, src;
      logic hs0, hs1, tog, hs;

      // ---------------- reset values ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tvalid",  32'(m_tvalid), 32'd0);
      chk("rst_tdata",   m_tdata, 32'd0);
      chk("rst_tlast",   32'(m_tlast), 32'd0);
      chk("rst_grant",   32'(grant), 32'd0);
      chk("rst_tready",  32'({s1_tready, s0_tready}), 32'd0);
      chk("rst_cntr_s0", cntr_s0, 32'd0);
      chk("rst_cntr_s1", cntr_s1, 32'd0);
      chk("rst_err",     32'(err), 32'd0);
      rst_n = 1'b1;

      // ---------------- 1: single 3-word s0 frame ----------------
      s0_tvalid = 1'b1; s0_tdata = 32'hA000_0000; s0_tlast = 1'b0;
      #1;
      chk("t1_arb_tvalid", 32'(m_tvalid), 32'd0);
      chk("t1_arb_tready", 32'(s0_tready), 32'd0);
      step();
      chk("t1_w0_tvalid", 32'(m_tvalid), 32'd1);
      chk("t1_w0_tdata",  m_tdata, 32'hA000_0000);
      chk("t1_w0_grant",  32'(grant), 32'd1);
      chk("t1_w0_tready", 32'(s0_tready), 32'd1);
      step();
      s0_tdata = 32'hA000_0001;
      #1;
      chk("t1_w1_tdata", m_tdata, 32'hA000_0001);
      chk("t1_w1_tlast", 32'(m_tlast), 32'd0);
      step();
      s0_tdata = 32'hA000_0002; s0_tlast = 1'b1;
      #1;
      chk("t1_w2_tdata", m_tdata, 32'hA000_0002);
      chk("t1_w2_tlast", 32'(m_tlast), 32'd1);
      step();
      s0_tvalid = 1'b0; s0_tlast = 1'b0;
      #1;
      chk("t1_end_grant",  32'(grant), 32'd0);
      chk("t1_end_tvalid", 32'(m_tvalid), 32'd0);
      chk("t1_cntr_s0",    cntr_s0, 32'd1);

      // ---------------- 2: both sources busy, 2-word frames ----------------
      // Fresh reset so the first tie goes to s0.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      idx0 = 0; idx1 = 0;
      s0_tvalid = 1'b1; s1_tvalid = 1'b1;
      for (int f = 0; f < 4; f++) begin
         src = f % 2;
         for (int c = 0; c < 3; c++) begin
            s0_tdata = 32'h5000_0000 + 32'(idx0); s0_tlast = idx0[0];
            s1_tdata = 32'h6000_0000 + 32'(idx1); s1_tlast = idx1[0];
            #1;
            if (c == 0) begin
               chk("t2_arb_tvalid", 32'(m_tvalid), 32'd0);
            end else begin
               chk("t2_grant", 32'(grant), (src == 0) ? 32'd1 : 32'd2);
               chk("t2_tdata", m_tdata,
                   ((src == 0) ? 32'h5000_0000 : 32'h6000_0000) + 32'((f / 2) * 2 + (c - 1)));
               chk("t2_tlast", 32'(m_tlast), 32'(c - 1));
            end
            hs0 = s0_tvalid & s0_tready;
            hs1 = s1_tvalid & s1_tready;
            step();
            if (hs0) idx0++;
            if (hs1) idx1++;
         end
      end
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      chk("t2_cntr_s0", cntr_s0, 32'd2);
      chk("t2_cntr_s1", cntr_s1, 32'd2);

      // counter clear pulse
      rst_cntr = 1'b1;
      step();
      rst_cntr = 1'b0;
      chk("clr_cntr_s0", cntr_s0, 32'd0);
      chk("clr_cntr_s1", cntr_s1, 32'd0);

      // ---------------- 3: toggled backpressure on 4-word s1 frame ----------------
      k = 0; n = 0; tog = 1'b1;
      s1_tvalid = 1'b1; s1_tdata = 32'hC000_0000; s1_tlast = 1'b0;
      #1;
      chk("t3_arb_tready", 32'(s1_tready), 32'd0);
      step();
      while (k < 4 && n < 20) begin
         m_tready = tog;
         tog = ~tog;
         s1_tdata = 32'hC000_0000 + 32'(k);
         s1_tlast = (k == 3);
         #1;
         chk("t3_tdata",  m_tdata, 32'hC000_0000 + 32'(k));
         chk("t3_tlast",  32'(m_tlast), (k == 3) ? 32'd1 : 32'd0);
         chk("t3_tready", 32'(s1_tready), 32'(m_tready));
         hs = m_tready;
         step();
         if (hs) k++;
         n++;
      end
      chk("t3_words_done", 32'(k), 32'd4);
      chk("t3_cycles", 32'(n), 32'd7);
      s1_tvalid = 1'b0; s1_tlast = 1'b0; m_tready = 1'b1;
      #1;
      chk("t3_grant",   32'(grant), 32'd0);
      chk("t3_cntr_s1", cntr_s1, 32'd1);
      chk("t3_err",     32'(err), 32'd0);

      // ---------------- 4: stall abort on s0 (timeout 8) ----------------
      s0_tvalid = 1'b1; s0_tdata = 32'h4000_0000; s0_tlast = 1'b0;
      s1_tvalid = 1'b1; s1_tdata = 32'hE1E1_E1E1; s1_tlast = 1'b1;
      #1;
      chk("t4_arb_tvalid", 32'(m_tvalid), 32'd0);
      step();
      chk("t4_w0_grant", 32'(grant), 32'd1);
      chk("t4_w0_tdata", m_tdata, 32'h4000_0000);
      step();
      s0_tdata = 32'h4000_0001;
      #1;
      chk("t4_w1_tdata", m_tdata, 32'h4000_0001);
      step();
      s0_tvalid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t4_stall_tvalid", 32'(m_tvalid), 32'd0);
         chk("t4_stall_grant",  32'(grant), 32'd1);
         chk("t4_stall_s1rdy",  32'(s1_tready), 32'd0);
         step();
      end
      m_tready = 1'b0;
      #1;
      chk("t4_term_tvalid", 32'(m_tvalid), 32'd1);
      chk("t4_term_tdata",  m_tdata, 32'hDEAD_F00D);
      chk("t4_term_tlast",  32'(m_tlast), 32'd1);
      chk("t4_term_err",    32'(err), 32'd1);
      chk("t4_term_s0rdy",  32'(s0_tready), 32'd0);
      step();
      chk("t4_term_hold_tvalid", 32'(m_tvalid), 32'd1);
      chk("t4_term_hold_tdata",  m_tdata, 32'hDEAD_F00D);
      m_tready = 1'b1;
      step();
      chk("t4_drain_tvalid", 32'(m_tvalid), 32'd0);
      chk("t4_drain_s0rdy",  32'(s0_tready), 32'd1);
      chk("t4_drain_s1rdy",  32'(s1_tready), 32'd0);
      step();
      s0_tvalid = 1'b1; s0_tdata = 32'h4000_0002; s0_tlast = 1'b0;
      #1;
      chk("t4_drop0_tvalid", 32'(m_tvalid), 32'd0);
      chk("t4_drop0_s0rdy",  32'(s0_tready), 32'd1);
      step();
      s0_tdata = 32'h4000_0003; s0_tlast = 1'b1;
      #1;
      chk("t4_drop1_tvalid", 32'(m_tvalid), 32'd0);
      step();
      s0_tvalid = 1'b0; s0_tlast = 1'b0;
      #1;
      chk("t4_idle_grant", 32'(grant), 32'd0);
      chk("t4_cntr_s0",    cntr_s0, 32'd0);
      step();
      chk("t4_s1_grant", 32'(grant), 32'd2);
      chk("t4_s1_tdata", m_tdata, 32'hE1E1_E1E1);
      chk("t4_s1_tlast", 32'(m_tlast), 32'd1);
      step();
      s1_tvalid = 1'b0; s1_tlast = 1'b0;
      chk("t4_cntr_s1", cntr_s1, 32'd2);
      chk("t4_err_sticky", 32'(err), 32'd1);

      // ---------------- 5: disabled source, counter clear ----------------
      src_en = 2'b01;
      s1_tvalid = 1'b1; s1_tdata = 32'h7777_0000; s1_tlast = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_grant",  32'(grant), 32'd0);
         chk("t5_s1rdy",  32'(s1_tready), 32'd0);
      end
      rst_cntr = 1'b1;
      step();
      rst_cntr = 1'b0;
      chk("t5_cntr_s0", cntr_s0, 32'd0);
      chk("t5_cntr_s1", cntr_s1, 32'd0);
      chk("t5_err",     32'(err), 32'd0);
      s1_tvalid = 1'b0; s1_tlast = 1'b0;

      // ---------------- 6: async reset mid-frame ----------------
      src_en = 2'b11;
      s1_tvalid = 1'b1; s1_tdata = 32'h6600_0000; s1_tlast = 1'b0;
      step();
      chk("t6_grant1",  32'(grant), 32'd2);
      chk("t6_tvalid1", 32'(m_tvalid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("t6_rst_tdata",  m_tdata, 32'd0);
      chk("t6_rst_grant",  32'(grant), 32'd0);
      chk("t6_rst_s1rdy",  32'(s1_tready), 32'd0);
      step();
      rst_n = 1'b1;
      s0_tvalid = 1'b1; s0_tdata = 32'h1111_0000; s0_tlast = 1'b1;
      #1;
      chk("t6_arb_tvalid", 32'(m_tvalid), 32'd0);
      step();
      chk("t6_tie_grant", 32'(grant), 32'd1);
      chk("t6_tie_tdata", m_tdata, 32'h1111_0000);
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
